// File: rtl/multipler_job_sequencer.sv
// multipler_job_sequencer
// Queues operand pairs in a small FIFO, launches each pair on the multiplier with a
// one-cycle start pulse, holds the operands until finish, then presents the captured
// product on a valid/ready result port.
module multipler_job_sequencer #(
  parameter int DATA_LENGTH = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_LENGTH-1:0]   in_a_i,
  input  logic [DATA_LENGTH-1:0]   in_b_i,
  output logic                     mul_start_o,
  output logic [DATA_LENGTH-1:0]   mul_a_o,
  output logic [DATA_LENGTH-1:0]   mul_b_o,
  input  logic                     mul_busy_i,
  input  logic                     mul_finish_i,
  input  logic [2*DATA_LENGTH-1:0] mul_result_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [2*DATA_LENGTH-1:0] res_data_o,
  output logic [CNT_WIDTH-1:0]     jobs_done_o,
  output logic                     idle_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Operand storage; pointers wrap naturally because FIFO_DEPTH is a power of two.
  logic [DATA_LENGTH-1:0] mem_a_q [FIFO_DEPTH];
  logic [DATA_LENGTH-1:0] mem_b_q [FIFO_DEPTH];

  state_t                   state_q,     state_d;
  logic [PTR_W:0]           count_q,     count_d;
  logic [PTR_W-1:0]         wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q,    rd_ptr_d;
  logic                     mul_start_q, mul_start_d;
  logic [DATA_LENGTH-1:0]   mul_a_q,     mul_a_d;
  logic [DATA_LENGTH-1:0]   mul_b_q,     mul_b_d;
  logic                     res_valid_q, res_valid_d;
  logic [2*DATA_LENGTH-1:0] res_data_q,  res_data_d;
  logic [CNT_WIDTH-1:0]     jobs_done_q, jobs_done_d;

  logic push;
  logic launch;

  // Ready depends only on the registered count, so a full FIFO refuses a push even while popping.
  assign in_ready_o = (count_q != FULL_COUNT);
  assign push       = in_valid_i && in_ready_o;

  // A job may start only when the result slot is free now or is being drained on this edge.
  assign launch = (state_q == ST_IDLE) && (count_q != '0) && !mul_busy_i &&
                  (!res_valid_q || res_ready_i);

  // FIFO storage write; contents need no reset since the count qualifies every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_a_i;
      mem_b_q[wr_ptr_q] <= in_b_i;
    end
  end

  // Next-state logic for the FIFO bookkeeping, the launch FSM and the result port.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    jobs_done_d = jobs_done_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    case ({push, launch})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase

    if (res_valid_q && res_ready_i) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          mul_a_d     = mem_a_q[rd_ptr_q];
          mul_b_d     = mem_b_q[rd_ptr_q];
          rd_ptr_d    = rd_ptr_q + PTR_W'(1);
          mul_start_d = 1'b1;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Busy is deliberately ignored here; only finish ends the job.
        if (mul_finish_i) begin
          res_data_d  = mul_result_i;
          res_valid_d = 1'b1;
          jobs_done_d = jobs_done_q + CNT_WIDTH'(1);
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any job in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      jobs_done_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      jobs_done_q <= jobs_done_d;
    end
  end

  assign mul_start_o = mul_start_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign jobs_done_o = jobs_done_q;
  assign idle_o      = (count_q == '0) && (state_q == ST_IDLE) && !res_valid_q;

endmodule

// File: tb/tb_multipler_job_sequencer.sv
// Testbench for multipler_job_sequencer: behavioural multiplier with random latency,
// queue-based scoreboard of expected products, directed scenarios plus a random run.
module tb_multipler_job_sequencer;

  localparam int DL = 32;
  localparam int FD = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid;
  logic          in_ready;
  logic [DL-1:0] in_a;
  logic [DL-1:0] in_b;
  logic          mul_start;
  logic [DL-1:0] mul_a;
  logic [DL-1:0] mul_b;
  logic          mul_busy;
  logic          mul_finish;
  logic [2*DL-1:0] mul_result;
  logic          res_valid;
  logic          res_ready;
  logic [2*DL-1:0] res_data;
  logic [CW-1:0] jobs_done;
  logic          idle;

  int tests_run = 0;
  int tests_failed = 0;

  multipler_job_sequencer #(
    .DATA_LENGTH(DL),
    .FIFO_DEPTH (FD),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .mul_start_o (mul_start),
    .mul_a_o     (mul_a),
    .mul_b_o     (mul_b),
    .mul_busy_i  (mul_busy),
    .mul_finish_i(mul_finish),
    .mul_result_i(mul_result),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .jobs_done_o (jobs_done),
    .idle_o      (idle)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural multiplier: start/busy/finish with random latency.
  logic          mdl_busy;
  logic          mdl_fin;
  logic          spur_fin;
  logic [2*DL-1:0] mdl_res;
  logic [DL-1:0] lat_a;
  logic [DL-1:0] lat_b;
  int            mdl_cnt;

  assign mul_busy   = mdl_busy;
  assign mul_finish = mdl_fin | spur_fin;
  assign mul_result = mdl_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_busy <= 1'b0;
      mdl_fin  <= 1'b0;
      mdl_res  <= '0;
      mdl_cnt  <= 0;
      lat_a    <= '0;
      lat_b    <= '0;
    end else begin
      mdl_fin <= 1'b0;
      if (!mdl_busy) begin
        if (mul_start) begin
          mdl_busy <= 1'b1;
          mdl_cnt  <= int'($urandom_range(1, 6));
          lat_a    <= mul_a;
          lat_b    <= mul_b;
        end
      end else if (mdl_cnt == 0) begin
        mdl_busy <= 1'b0;
        mdl_fin  <= 1'b1;
        mdl_res  <= 64'(mul_a) * 64'(mul_b);
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  // Scoreboard: every accepted pair must come back as a*b, in order.
  logic [63:0] exp_q[$];
  int          pushed = 0;
  int          consumed = 0;
  int          starts = 0;
  logic        prev_start = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pushed     = 0;
      consumed   = 0;
      prev_start = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(64'(in_a) * 64'(in_b));
        pushed++;
      end
      if (mul_start) begin
        starts++;
        check_eq("start_width", {63'b0, prev_start}, 64'd0);
      end
      prev_start = mul_start;
      if (mdl_fin) begin
        check_eq("hold_a", 64'(mul_a), 64'(lat_a));
        check_eq("hold_b", 64'(mul_b), 64'(lat_b));
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("res_extra", {63'b0, res_valid}, 64'd0);
        end else begin
          check_eq("res_data", res_data, exp_q.pop_front());
          consumed++;
          check_eq("jobs_done", 64'(jobs_done), 64'(consumed % (1 << CW)));
        end
      end
    end
  end

  task automatic push(input logic [DL-1:0] a, input logic [DL-1:0] b);
    logic took;
    int   n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    took     = 1'b0;
    n        = 0;
    while (!took && n < 500) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!took) check_eq("tmo_push", {63'b0, in_ready}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_res_valid();
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) check_eq("tmo_valid", {63'b0, res_valid}, 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!idle && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!idle) check_eq("tmo_idle", {63'b0, idle}, 64'd1);
  endtask

  initial begin
    int s0;
    int sent;
    int cyc;
    logic took;

    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b0;
    spur_fin  = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_start", {63'b0, mul_start}, 64'd0);
    check_eq("rst_valid", {63'b0, res_valid}, 64'd0);
    check_eq("rst_jobs", 64'(jobs_done), 64'd0);
    check_eq("rst_ready", {63'b0, in_ready}, 64'd1);
    check_eq("rst_idle", {63'b0, idle}, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1. Single job
    res_ready = 1'b1;
    s0 = starts;
    push(32'h3, 32'h5);
    wait_res_valid();
    check_eq("t1_data", res_data, 64'hF);
    check_eq("t1_jobs", 64'(jobs_done), 64'd1);
    wait_idle();
    check_eq("t1_starts", 64'(starts - s0), 64'd1);
    check_eq("t1_idle", {63'b0, idle}, 64'd1);

    // 2. Fill FIFO with the result port blocked
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push($urandom, $urandom);
    check_eq("t2_full_ready", {63'b0, in_ready}, 64'd0);
    in_valid = 1'b1;
    in_a     = $urandom;
    in_b     = $urandom;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("t2_still_full", {63'b0, in_ready}, 64'd0);
    res_ready = 1'b1;
    wait_idle();
    check_eq("t2_drain", 64'(consumed), 64'(pushed));

    // 3. Result back-pressure
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    push($urandom, $urandom);
    push($urandom, $urandom);
    wait_res_valid();
    s0 = starts;
    repeat (20) @(negedge clk);
    check_eq("t3_no_start", 64'(starts), 64'(s0));
    check_eq("t3_held", {63'b0, res_valid}, 64'd1);
    check_eq("t3_first", res_data, exp_q[0]);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_idle();
    check_eq("t3_drain", 64'(consumed), 64'(pushed));

    // 4. Operand boundaries
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(32'h0, 32'hDEAD_BEEF);
    wait_res_valid();
    check_eq("t4_max", res_data, 64'hFFFF_FFFE_0000_0001);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    wait_res_valid();
    check_eq("t4_zero", res_data, 64'h0);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_idle();

    // 5. Reset while a job is in WAIT with two entries queued
    push($urandom, $urandom);
    push($urandom, $urandom);
    push($urandom, $urandom);
    cyc = 0;
    @(negedge clk);
    while (!mdl_busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t5_busy", {63'b0, mdl_busy}, 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("t5_start", {63'b0, mul_start}, 64'd0);
    check_eq("t5_mul_a", 64'(mul_a), 64'd0);
    check_eq("t5_mul_b", 64'(mul_b), 64'd0);
    check_eq("t5_valid", {63'b0, res_valid}, 64'd0);
    check_eq("t5_data", res_data, 64'd0);
    check_eq("t5_jobs", 64'(jobs_done), 64'd0);
    check_eq("t5_ready", {63'b0, in_ready}, 64'd1);
    check_eq("t5_idle", {63'b0, idle}, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(32'd7, 32'd9);
    wait_res_valid();
    check_eq("t5_after", res_data, 64'd63);
    check_eq("t5_after_jobs", 64'(jobs_done), 64'd1);
    wait_idle();

    // 6. Spurious finish in IDLE
    @(posedge clk);
    #1;
    spur_fin = 1'b1;
    @(posedge clk);
    #1;
    spur_fin = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t6_valid", {63'b0, res_valid}, 64'd0);
    check_eq("t6_jobs", 64'(jobs_done), 64'(consumed % (1 << CW)));

    // 7. Random traffic with random back-pressure; jobs_done wraps here
    sent = 0;
    cyc  = 0;
    took = 1'b0;
    while (sent < 150 && cyc < 20000) begin
      @(posedge clk);
      #1;
      if (took) begin
        sent++;
        in_valid = 1'b0;
      end
      res_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 150 && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        case ($urandom_range(0, 7))
          0:       begin in_a = 32'hFFFF_FFFF; in_b = $urandom; end
          1:       begin in_a = $urandom;      in_b = 32'h0;    end
          default: begin in_a = $urandom;      in_b = $urandom; end
        endcase
      end
      @(negedge clk);
      took = in_valid && in_ready;
      cyc++;
    end
    check_eq("t7_sent", 64'(sent), 64'd150);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    wait_idle();
    check_eq("t7_drain", 64'(consumed), 64'(pushed));
    check_eq("t7_jobs", 64'(jobs_done), 64'(consumed % (1 << CW)));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
